// File: rtl/lbist_tpg_c432_pkg.sv
// Shared definitions for the c432 logic-BIST pattern path: session states,
// CUT input width, default LFSR polynomial/seed and the frame cadence shared with the MISR.
package lbist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int C432_IN_WIDTH = 36;

   // x^36 + x^11 + 1, expressed as a Fibonacci tap mask (bits 35 and 10)
   localparam logic [C432_IN_WIDTH-1:0] DEFAULT_POLY = 36'h8_0000_0400;
   localparam logic [C432_IN_WIDTH-1:0] DEFAULT_SEED = 36'h0_0000_0001;

   localparam int LBIST_FRAME_LEN = 8;

endpackage

// File: rtl/lbist_tpg_c432_if.sv
// Controller-to-TPG bundle: session request/seed in, CUT stimulus and session status out.
interface lbist_tpg_c432_if #(
   parameter int WIDTH = 36
);
   logic             start;
   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] pattern;
   logic             pattern_valid;
   logic [2:0]       frame_idx;
   logic             frame_last;
   logic             busy;
   logic             done;
   logic [15:0]      pattern_count;

   modport master (
      output start, seed_load, seed_in,
      input  pattern, pattern_valid, frame_idx, frame_last, busy, done, pattern_count
   );

   modport slave (
      input  start, seed_load, seed_in,
      output pattern, pattern_valid, frame_idx, frame_last, busy, done, pattern_count
   );
endinterface

// File: rtl/lbist_tpg_c432_lfsr.sv
// Fibonacci LFSR with load / advance / hold; shifts left and feeds the tap parity into bit 0.
module lbist_lfsr
   import lbist_pkg::*;
#(
   parameter int               WIDTH = C432_IN_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
   parameter logic [WIDTH-1:0] INIT  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= INIT;
      end else if (load) begin
         state_reg <= load_value;
      end else if (advance) begin
         state_reg <= {state_reg[WIDTH-2:0], ^(state_reg & POLY)};
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/lbist_tpg_c432.sv
// LFSR test-pattern generator and session sequencer for the c432 BIST path (7 pattern + 1 unload slot frames).
// Optional build macro TPG_PHASE_SHIFTER_EN inserts an XOR phase shifter between LFSR and CUT.
module lbist_tpg_c432
   import lbist_pkg::*;
#(
   parameter int               WIDTH        = C432_IN_WIDTH,
   parameter logic [WIDTH-1:0] POLY         = DEFAULT_POLY,
   parameter logic [WIDTH-1:0] SEED         = DEFAULT_SEED,
   parameter int               NUM_PATTERNS = 128,
   parameter int               FRAME_LEN    = LBIST_FRAME_LEN
) (
   input  logic             clk,
   input  logic             rst,
   lbist_tpg_c432_if.slave  bus
);

   localparam logic [2:0]  LAST_SLOT = 3'(FRAME_LEN - 1);
   localparam logic [15:0] NUM_P     = 16'(NUM_PATTERNS);

   state_t           state_reg, state_next;
   logic [2:0]       slot_reg;
   logic [15:0]      count_reg;
   logic [WIDTH-1:0] pattern_reg;
   logic             valid_reg, last_reg, busy_reg, done_reg;
   logic [2:0]       frame_idx_reg;

   logic             accept, finish, last_slot, issue_valid;
   logic [WIDTH-1:0] seed_pick, seed_val, lfsr_q, shaped;

   lbist_lfsr #(.WIDTH(WIDTH), .POLY(POLY), .INIT(SEED)) u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .advance    (issue_valid),
      .load_value (seed_val),
      .state      (lfsr_q)
   );

`ifdef TPG_PHASE_SHIFTER_EN
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_phase
      assign shaped[gi] = lfsr_q[gi] ^ lfsr_q[(gi + 7) % WIDTH] ^ lfsr_q[(gi + 19) % WIDTH];
   end
`else
   assign shaped = lfsr_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A session ends on the edge after its final unload slot: slot counter has wrapped with the quota met.
   always_comb begin
      state_next  = state_reg;
      seed_pick   = bus.seed_load ? bus.seed_in : SEED;
      seed_val    = (seed_pick == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_pick;
      accept      = 1'b0;
      last_slot   = (slot_reg == LAST_SLOT);
      finish      = 1'b0;
      issue_valid = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            finish      = (slot_reg == 3'd0) && (count_reg == NUM_P);
            issue_valid = !finish && !last_slot && (count_reg < NUM_P);
            if (finish) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_reg      <= '0;
         count_reg     <= '0;
         pattern_reg   <= '0;
         valid_reg     <= 1'b0;
         last_reg      <= 1'b0;
         frame_idx_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         busy_reg <= (state_next == RUN);
         done_reg <= (state_next == DONE);
         if (accept) begin
            slot_reg      <= '0;
            count_reg     <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            frame_idx_reg <= '0;
         end else if (state_reg == RUN && !finish) begin
            frame_idx_reg <= slot_reg;
            last_reg      <= last_slot;
            valid_reg     <= issue_valid;
            slot_reg      <= last_slot ? 3'd0 : slot_reg + 3'd1;
            if (issue_valid) begin
               pattern_reg <= shaped;
               count_reg   <= count_reg + 16'd1;
            end
         end
      end
   end

   assign bus.pattern       = pattern_reg;
   assign bus.pattern_valid = valid_reg;
   assign bus.frame_idx     = frame_idx_reg;
   assign bus.frame_last    = last_reg;
   assign bus.busy          = busy_reg;
   assign bus.done          = done_reg;
   assign bus.pattern_count = count_reg;

endmodule

// File: tb/tb_lbist_tpg_c432.sv
// Directed bench for lbist_tpg_c432: two instances (128 and 10 patterns) share stimulus and are
// checked every cycle against a session-position model, plus hand-computed literal expectations.
module tb_lbist_tpg_c432;

   localparam logic [35:0] TB_POLY = 36'h8_0000_0400;

   typedef struct packed {
      logic [35:0] pat;
      logic        valid;
      logic [2:0]  fidx;
      logic        last;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        seed_load;
   logic [35:0] seed_in;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lbist_tpg_c432_if #(.WIDTH(36)) i0 ();
   lbist_tpg_c432_if #(.WIDTH(36)) i1 ();

   assign i0.start = start;  assign i0.seed_load = seed_load;  assign i0.seed_in = seed_in;
   assign i1.start = start;  assign i1.seed_load = seed_load;  assign i1.seed_in = seed_in;

   lbist_tpg_c432 #(.NUM_PATTERNS(128)) dut0 (.clk(clk), .rst(rst), .bus(i0));
   lbist_tpg_c432 #(.NUM_PATTERNS(10))  dut1 (.clk(clk), .rst(rst), .bus(i1));

   obs_t d_obs [2];
   assign d_obs[0] = {i0.pattern, i0.pattern_valid, i0.frame_idx, i0.frame_last, i0.busy, i0.done, i0.pattern_count};
   assign d_obs[1] = {i1.pattern, i1.pattern_valid, i1.frame_idx, i1.frame_last, i1.busy, i1.done, i1.pattern_count};

   task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: position within a session ----------------
   logic        m_init = 1'b0;
   logic        m_sess [2];
   int          m_k    [2];
   logic [35:0] m_seed [2];
   logic [35:0] m_hold [2];

   function automatic int num_of(input int i);
      return (i == 0) ? 128 : 10;
   endfunction

   function automatic int len_of(input int i);
      return ((num_of(i) + 6) / 7) * 8;
   endfunction

   function automatic logic [35:0] nth(input logic [35:0] s, input int n);
      logic [35:0] v = s;
      for (int j = 0; j < n; j++) v = {v[34:0], ^(v & TB_POLY)};
      return v;
   endfunction

   function automatic obs_t expect_out(input int i);
      obs_t o = '0;
      int   k = m_k[i];
      int   n = num_of(i);
      int   slot, fr, c;
      if (!m_sess[i]) begin
         o.pat = m_hold[i];
      end else if (k == 0) begin
         o.pat  = m_hold[i];
         o.busy = 1'b1;
      end else if (k <= len_of(i)) begin
         slot = (k - 1) % 8;
         fr   = (k - 1) / 8;
         c    = fr * 7 + ((slot < 7) ? slot + 1 : 7);
         if (c > n) c = n;
         o.busy  = 1'b1;
         o.fidx  = 3'(slot);
         o.last  = (slot == 7);
         o.cnt   = 16'(c);
         o.valid = (slot < 7) && (fr * 7 + slot < n);
         o.pat   = nth(m_seed[i], c - 1);
      end else begin
         o.done = 1'b1;
         o.fidx = 3'd7;
         o.last = 1'b1;
         o.cnt  = 16'(n);
         o.pat  = nth(m_seed[i], n - 1);
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (rst) m_init <= 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_sess[i] <= 1'b0;
            m_k[i]    <= 0;
            m_hold[i] <= '0;
         end else if (m_init) begin
            if (start && (!m_sess[i] || m_k[i] > len_of(i))) begin
               m_sess[i] <= 1'b1;
               m_k[i]    <= 0;
               m_seed[i] <= (!seed_load) ? 36'h1 : ((seed_in == '0) ? 36'h1 : seed_in);
               m_hold[i] <= expect_out(i).pat;
            end else if (m_sess[i] && m_k[i] <= len_of(i)) begin
               m_k[i] <= m_k[i] + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (m_init) begin
         for (int i = 0; i < 2; i++) begin
            obs_t e;
            e = expect_out(i);
            check($sformatf("u%0d pattern", i),       d_obs[i].pat,          e.pat);
            check($sformatf("u%0d pattern_valid", i), 36'(d_obs[i].valid),   36'(e.valid));
            check($sformatf("u%0d frame_idx", i),     36'(d_obs[i].fidx),    36'(e.fidx));
            check($sformatf("u%0d frame_last", i),    36'(d_obs[i].last),    36'(e.last));
            check($sformatf("u%0d busy", i),          36'(d_obs[i].busy),    36'(e.busy));
            check($sformatf("u%0d done", i),          36'(d_obs[i].done),    36'(e.done));
            check($sformatf("u%0d pattern_count", i), 36'(d_obs[i].cnt),     36'(e.cnt));
         end
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic pulse_start(input logic sl, input logic [35:0] si);
      seed_load = sl;
      seed_in   = si;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      seed_in   = '0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!(i0.done && i1.done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({nm, " done timeout"}, 36'(i0.done && i1.done), 36'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; seed_load = 1'b0; seed_in = '0;
      @(negedge clk); @(negedge clk);
      check("rst pattern", i0.pattern, 36'h0);
      check("rst busy", 36'(i0.busy), 36'd0);
      check("rst done", 36'(i0.done), 36'd0);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      check("idle after rst busy", 36'(i0.busy), 36'd0);

      // default seed session; a start pulse mid-RUN with a junk seed must be ignored
      pulse_start(1'b0, '0);
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         case (k)
            0:  check("k0 busy", 36'(i0.busy), 36'd1);
            1:  begin check("k1 pattern", i0.pattern, 36'h1); check("k1 valid", 36'(i0.pattern_valid), 36'd1); end
            7:  begin check("k7 pattern", i0.pattern, 36'h40); check("k7 count", 36'(i0.pattern_count), 36'd7); end
            8:  begin check("k8 last", 36'(i0.frame_last), 36'd1); check("k8 valid", 36'(i0.pattern_valid), 36'd0);
                      check("k8 hold", i0.pattern, 36'h40); end
            12: begin check("k12 pattern", i0.pattern, 36'h400); check("u1 k12 valid", 36'(i1.pattern_valid), 36'd0);
                      check("u1 k12 hold", i1.pattern, 36'h200); end
            13: check("k13 pattern", i0.pattern, 36'h801);
            16: begin check("u1 k16 busy", 36'(i1.busy), 36'd1); check("u1 k16 done", 36'(i1.done), 36'd0); end
            17: begin check("u1 k17 done", 36'(i1.done), 36'd1); check("u1 k17 busy", 36'(i1.busy), 36'd0);
                      check("u1 k17 count", 36'(i1.pattern_count), 36'd10); end
            default: ;
         endcase
         if (k == 3) begin start = 1'b1; seed_load = 1'b1; seed_in = 36'hF_FFFF_FFFF; end
         else if (k == 4) begin start = 1'b0; seed_load = 1'b0; seed_in = '0; end
      end
      wait_done("s1");

      // restart from DONE with a zero user seed
      pulse_start(1'b1, 36'h0);
      @(negedge clk);
      check("zero seed u0", i0.pattern, 36'h1);
      check("zero seed u1", i1.pattern, 36'h1);
      wait_done("s2");

      // user seed, then reset at frame_idx 4 of the second frame
      pulse_start(1'b1, 36'h9_8765_4321);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1) check("user seed k1", i0.pattern, 36'h9_8765_4321);
         if (k == 2) check("user seed k2", i0.pattern, 36'h3_0ECA_8643);
      end
      check("pre-rst frame_idx", 36'(i0.frame_idx), 36'd4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid rst valid", 36'(i0.pattern_valid), 36'd0);
      check("mid rst count", 36'(i0.pattern_count), 36'd0);
      check("mid rst done", 36'(i0.done), 36'd0);

      pulse_start(1'b0, '0);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1) check("replay k1", i0.pattern, 36'h1);
      end
      check("replay k13", i0.pattern, 36'h801);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
